// File: rtl/fu_slot_scheduler.sv
// Occupancy scheduler for a pool of non-pipelined multi-cycle FUs: binds dispatch slots to free units
// and tracks each unit IDLE -> BUSY -> DONE until CDB ack. Optional FU_SLOT_ACK_BYPASS_EN frees acked units same-cycle.
module fu_slot_scheduler #(
    parameter int I_WIDTH    = 3,
    parameter int NUM_UNITS  = 4,
    parameter int LATENCY    = 4,
    localparam int CNT_LEN   = $clog2(I_WIDTH + 1),
    localparam int UIDX_LEN  = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [I_WIDTH-1:0]           dispatch_valid,
    output logic [CNT_LEN-1:0]           empty_slots,
    output logic [NUM_UNITS-1:0]         unit_start,
    output logic [I_WIDTH*UIDX_LEN-1:0]  slot_unit,
    output logic [NUM_UNITS-1:0]         result_valid,
    input  logic [NUM_UNITS-1:0]         cdb_ack,
    output logic                         overflow_err
);

    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } unit_state_t;

    logic [NUM_UNITS-1:0] idle_vec;
    logic [NUM_UNITS-1:0] done_vec;
    logic [NUM_UNITS-1:0] free_vec;
    logic [NUM_UNITS-1:0] taken_vec;
    logic [NUM_UNITS-1:0] start_vec;
    logic                 ovf_hit;
    logic                 overflow_reg;
    int                   free_total;

    // An acked DONE unit may be reused in the same cycle only when bypass is compiled in.
`ifdef FU_SLOT_ACK_BYPASS_EN
    assign free_vec = idle_vec | (done_vec & cdb_ack);
`else
    assign free_vec = idle_vec;
`endif

    always_comb begin
        free_total = 0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (free_vec[u]) begin
                free_total = free_total + 1;
            end
        end
    end

    assign empty_slots = (free_total > I_WIDTH) ? CNT_LEN'(I_WIDTH) : CNT_LEN'(free_total);

    // Each valid slot below empty_slots takes the lowest-indexed free unit not already claimed.
    always_comb begin
        logic found;
        taken_vec = '0;
        slot_unit = '0;
        ovf_hit   = 1'b0;
        found     = 1'b0;
        for (int i = 0; i < I_WIDTH; i++) begin
            if (dispatch_valid[i]) begin
                if (i < int'(empty_slots)) begin
                    found = 1'b0;
                    for (int u = 0; u < NUM_UNITS; u++) begin
                        if (!found && free_vec[u] && !taken_vec[u]) begin
                            found        = 1'b1;
                            taken_vec[u] = 1'b1;
                            slot_unit[i*UIDX_LEN +: UIDX_LEN] = UIDX_LEN'(u);
                        end
                    end
                end else begin
                    ovf_hit = 1'b1;
                end
            end
        end
    end

    assign start_vec    = flush ? '0 : taken_vec;
    assign unit_start   = start_vec;
    assign result_valid = done_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
            unit_state_t   state_reg;
            unit_state_t   state_next;
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                if (flush) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (start_vec[gi]) begin
                    if (LATENCY == 1) begin
                        state_next = ST_DONE;
                        cnt_next   = '0;
                    end else begin
                        state_next = ST_BUSY;
                        cnt_next   = CW'(LATENCY - 1);
                    end
                end else begin
                    case (state_reg)
                        ST_BUSY: begin
                            if (cnt_reg == CW'(1)) begin
                                state_next = ST_DONE;
                                cnt_next   = '0;
                            end else begin
                                cnt_next = cnt_reg - CW'(1);
                            end
                        end
                        ST_DONE: begin
                            if (cdb_ack[gi]) begin
                                state_next = ST_IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end

            assign idle_vec[gi] = (state_reg == ST_IDLE);
            assign done_vec[gi] = (state_reg == ST_DONE);
        end
    endgenerate

    // Dispatches squashed by a flush are not counted as overflows.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow_reg <= 1'b0;
        end else if (ovf_hit && !flush) begin
            overflow_reg <= 1'b1;
        end
    end

    assign overflow_err = overflow_reg;

endmodule

// File: tb/tb_fu_slot_scheduler.sv
// Directed bench for fu_slot_scheduler at default parameters; bypass expectations follow FU_SLOT_ACK_BYPASS_EN.
module tb_fu_slot_scheduler;

    logic       clock;
    logic       reset;
    logic       flush;
    logic [2:0] dispatch_valid;
    logic [1:0] empty_slots;
    logic [3:0] unit_start;
    logic [5:0] slot_unit;
    logic [3:0] result_valid;
    logic [3:0] cdb_ack;
    logic       overflow_err;

    int checks = 0;
    int errors = 0;

    fu_slot_scheduler #(
        .I_WIDTH  (3),
        .NUM_UNITS(4),
        .LATENCY  (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .dispatch_valid(dispatch_valid),
        .empty_slots   (empty_slots),
        .unit_start    (unit_start),
        .slot_unit     (slot_unit),
        .result_valid  (result_valid),
        .cdb_ack       (cdb_ack),
        .overflow_err  (overflow_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset          = 1'b0;
        flush          = 1'b0;
        dispatch_valid = 3'b000;
        cdb_ack        = 4'b0000;
        tick();
        tick();
        #1;
        chk("rst_empty", 32'(empty_slots), 32'd3);
        chk("rst_start", 32'(unit_start), 32'd0);
        chk("rst_slot_unit", 32'(slot_unit), 32'd0);
        chk("rst_rv", 32'(result_valid), 32'd0);
        chk("rst_ovf", 32'(overflow_err), 32'd0);

        // Cycle A: release reset and dispatch two slots
        tick();
        reset          = 1'b1;
        dispatch_valid = 3'b011;
        #1;
        chk("disp2_start", 32'(unit_start), 32'b0011);
        chk("disp2_slot_unit", 32'(slot_unit), 32'h04);
        chk("disp2_empty", 32'(empty_slots), 32'd3);
        tick();
        dispatch_valid = 3'b000;
        #1;
        chk("a1_empty", 32'(empty_slots), 32'd2);
        chk("a1_rv", 32'(result_valid), 32'd0);
        tick();
        tick();
        #1;
        chk("a3_rv", 32'(result_valid), 32'd0);
        tick();
        #1;
        chk("a4_rv", 32'(result_valid), 32'b0011);

        // Results hold without ack
        for (int n = 0; n < 10; n++) begin
            tick();
            #1;
            chk("hold_rv", 32'(result_valid), 32'b0011);
        end
        chk("hold_empty", 32'(empty_slots), 32'd2);

        cdb_ack = 4'b0001;
        #1;
        chk("ack0_rv_same", 32'(result_valid), 32'b0011);
        tick();
        cdb_ack = 4'b0010;
        #1;
        chk("ack0_rv_next", 32'(result_valid), 32'b0010);
        chk("ack0_empty_next", 32'(empty_slots), 32'd3);
        tick();
        cdb_ack = 4'b0000;
        #1;
        chk("ack1_rv_next", 32'(result_valid), 32'b0000);

        // Fill units 0-2, then overflow with two slots against one free unit
        dispatch_valid = 3'b111;
        #1;
        chk("fill3_start", 32'(unit_start), 32'b0111);
        chk("fill3_slot_unit", 32'(slot_unit), 32'h24);
        tick();
        dispatch_valid = 3'b011;
        #1;
        chk("ovf_empty", 32'(empty_slots), 32'd1);
        chk("ovf_start", 32'(unit_start), 32'b1000);
        chk("ovf_slot_unit", 32'(slot_unit), 32'h03);
        chk("ovf_flag_same", 32'(overflow_err), 32'd0);
        tick();
        dispatch_valid = 3'b001;
        #1;
        chk("ovf_flag_next", 32'(overflow_err), 32'd1);
        chk("full_empty", 32'(empty_slots), 32'd0);
        chk("full_start", 32'(unit_start), 32'd0);
        tick();
        dispatch_valid = 3'b000;
        #1;
        chk("ovf_sticky", 32'(overflow_err), 32'd1);
        tick();

        // Units 0-2 DONE, unit 3 still BUSY: flush with a dispatch
        flush          = 1'b1;
        dispatch_valid = 3'b001;
        #1;
        chk("flush_rv_same", 32'(result_valid), 32'b0111);
        chk("flush_start", 32'(unit_start), 32'd0);
        tick();
        flush          = 1'b0;
        dispatch_valid = 3'b000;
        #1;
        chk("flush_rv_next", 32'(result_valid), 32'd0);
        chk("flush_empty_next", 32'(empty_slots), 32'd3);
        chk("flush_ovf_sticky", 32'(overflow_err), 32'd1);

        // Bring all four units to DONE
        dispatch_valid = 3'b111;
        #1;
        chk("all_start_a", 32'(unit_start), 32'b0111);
        tick();
        dispatch_valid = 3'b001;
        #1;
        chk("all_start_b", 32'(unit_start), 32'b1000);
        chk("all_slot_unit_b", 32'(slot_unit), 32'h03);
        tick();
        dispatch_valid = 3'b000;
        tick();
        tick();
        #1;
        chk("part_done_rv", 32'(result_valid), 32'b0111);
        tick();
        #1;
        chk("all_done_rv", 32'(result_valid), 32'b1111);
        chk("all_done_empty", 32'(empty_slots), 32'd0);

        cdb_ack        = 4'b0100;
        dispatch_valid = 3'b001;
        #1;
`ifdef FU_SLOT_ACK_BYPASS_EN
        chk("bypass_empty", 32'(empty_slots), 32'd1);
        chk("bypass_start", 32'(unit_start), 32'b0100);
        chk("bypass_slot_unit", 32'(slot_unit), 32'h02);
`else
        chk("nobypass_empty", 32'(empty_slots), 32'd0);
        chk("nobypass_start", 32'(unit_start), 32'd0);
`endif
        tick();
        cdb_ack        = 4'b0000;
        dispatch_valid = 3'b000;
        #1;
        chk("after_ack_rv", 32'(result_valid), 32'b1011);
`ifdef FU_SLOT_ACK_BYPASS_EN
        chk("after_ack_empty", 32'(empty_slots), 32'd0);
`else
        chk("after_ack_empty", 32'(empty_slots), 32'd1);
`endif

        // Asynchronous reset mid-cycle clears everything before the next edge
        reset = 1'b0;
        #1;
        chk("async_rst_rv", 32'(result_valid), 32'd0);
        chk("async_rst_empty", 32'(empty_slots), 32'd3);
        chk("async_rst_ovf", 32'(overflow_err), 32'd0);
        tick();
        reset = 1'b1;
        #1;
        chk("post_rst_empty", 32'(empty_slots), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fu_slot_scheduler.md
# fu_slot_scheduler

Occupancy scheduler for one pool of non-pipelined, multi-cycle functional units of a single FU type, such as multipliers. It sits between the issue queue and the FU pool and drives that type's `execute_empty_slots` entry. It binds each dispatched execute slot to a free unit and tracks every unit through busy → result-pending → free. It holds results until the CDB arbiter acknowledges them. One instance is built per multi-cycle FU type.

## Interface
- `I_WIDTH`, default 3: issue width, equal to the number of execute slots per FU type.
- `NUM_UNITS`, default 4: number of units in the pool, ≥1.
- `LATENCY`, default 4: cycles from start to result-valid, ≥1.
- Derived: `CNT_LEN = CAL_CNT_LEN(I_WIDTH)`; `UIDX_LEN = max(1, clog2(NUM_UNITS))`.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `flush`  in  1  pipeline flush, synchronous, active-high.
- `dispatch_valid`  in  I_WIDTH  valid bits of this type's execute slots. Valid slots are packed from index 0.
- `empty_slots`  out  CNT_LEN  free units offered to the issue queue, at most I_WIDTH.
- `unit_start`  out  NUM_UNITS  one-hot-per-unit start strobes for this cycle.
- `slot_unit`  out  I_WIDTH×UIDX_LEN  unit index bound to each dispatch slot; meaningful only where that slot's `dispatch_valid` is 1.
- `result_valid`  out  NUM_UNITS  unit holds a finished result awaiting the CDB.
- `cdb_ack`  in  NUM_UNITS  the CDB accepted that unit's result this cycle.
- `overflow_err`  out  1  sticky error flag: dispatch exceeded the offered slots.

## Operation
- Each unit has a 2-bit state: IDLE, BUSY, DONE. BUSY units also carry a down-counter `cnt` of width clog2(LATENCY+1).
- IDLE + start:
  - LATENCY==1 → DONE.
  - otherwise → BUSY with `cnt = LATENCY-1`.
- BUSY: decrement `cnt` each cycle; when `cnt==1`, go to DONE next cycle.
- DONE: `result_valid=1`. Hold DONE until `cdb_ack`, then go to IDLE next cycle.
- `cdb_ack` on a unit that is not DONE is ignored.
- Free count F = number of IDLE units. `empty_slots = min(F, I_WIDTH)`, computed from registered state only.
- Binding: the k-th set bit of `dispatch_valid` (k=0,1,…) goes to the k-th lowest-indexed IDLE unit. That unit gets `unit_start=1` and `slot_unit[k]` = its index.
- Overflow: valid slots with index ≥ `empty_slots` are dropped and get no start. `overflow_err` sets the next cycle and stays set until reset.
- Flush: every unit → IDLE next cycle and `unit_start` is forced to 0. `result_valid` still reflects current state during the flush cycle. `cdb_ack` in the flush cycle has no extra effect.

## Timing
- Reset values:
  - all units IDLE, `cnt=0`;
  - `empty_slots = min(NUM_UNITS, I_WIDTH)`;
  - `unit_start=0`, `slot_unit=0`, `result_valid=0`, `overflow_err=0`.
- Reset takes effect immediately and asynchronously, including mid-operation. Units in BUSY or DONE are discarded.
- Start at edge t: `result_valid` rises in the cycle after edge t+LATENCY-1, which is LATENCY cycles after the dispatch cycle.
- Ack in cycle c: the unit is IDLE and counted in `empty_slots` in cycle c+1, and can be started in cycle c+1.
- `unit_start` and `slot_unit` are combinational from `dispatch_valid` and state; they are valid in the same cycle as dispatch.
- All units full: `empty_slots=0` and every `dispatch_valid` bit is an overflow.
- Simultaneous ack on unit u and dispatch: u is not rebound in the same cycle unless bypass is enabled (see Configuration).

## Configuration
- Macro: `FU_SLOT_ACK_BYPASS_EN`.
- Defined: a DONE unit whose `cdb_ack` is 1 in the current cycle counts as free. It adds to F and `empty_slots`, and can take a start in that same cycle, going directly to BUSY (or to DONE when LATENCY==1). This creates a combinational path `cdb_ack` → `empty_slots`.
- Undefined: `empty_slots` depends only on registered state, and there is a one-cycle bubble after each ack.

## Test plan
- Reset then release with defaults (I_WIDTH=3, NUM_UNITS=4) → `empty_slots=3`, all outputs 0.
- `dispatch_valid=3'b011`, no acks → units 0 and 1 started, `slot_unit[0]=0`, `slot_unit[1]=1`. Next cycle `empty_slots=2`. `result_valid[1:0]` rises 4 cycles after dispatch.
- Hold `cdb_ack=0` for 10 cycles after DONE → `result_valid` stays 1. Pulse `cdb_ack[0]` → next cycle the unit is IDLE and `empty_slots` increments.
- Units 0–2 busy, `dispatch_valid=3'b011` → unit 3 starts and slot 1 is dropped; `overflow_err=1` next cycle and stays 1 until reset.
- Flush while units are in BUSY and DONE, with `dispatch_valid=3'b001` in the flush cycle → no `unit_start`; next cycle all IDLE, `empty_slots=3`, `result_valid=0`.
- With `FU_SLOT_ACK_BYPASS_EN`, all units DONE, `cdb_ack=4'b0100`, `dispatch_valid=3'b001` → same cycle `empty_slots=1` and `unit_start=4'b0100`. Without the macro: `empty_slots=0` and the dispatch is flagged as overflow.
